display_share_arbiter: RTL and testbench

Round-robin arbiter that shares the single four-digit seven-segment display between up to N_REQ requesting blocks, such as a counter, a status reporter or a debug monitor. It sits directly upstream of the display driver and owns that driver's num3..num0 inputs. At any moment it grants the display to exactly one requester or to none. It forwards the owner's digit codes with one registered stage, and it enforces a maximum hold time so no requester can starve the others.

---
 rtl/display_share_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_display_share_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_share_arbiter.sv
// Round-robin owner of the shared four-digit display.
// Optional blank gap between owners: DISP_ARB_GAP_EN.
module display_share_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = 100000000,
  parameter int GAP_CYCLES = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*24-1:0] digits_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [5:0]         num3,
  output logic [5:0]         num2,
  output logic [5:0]         num1,
  output logic [5:0]         num0,
  output logic               busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);
  localparam logic [5:0] OFF = 6'd16;

  typedef logic [PW-1:0] idx_t;

`ifdef DISP_ARB_GAP_EN
  typedef enum logic [1:0] {IDLE, OWN, GAP} st_t;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_TOP = GW'(GAP_CYCLES - 1);
  logic [GW-1:0] gap_q, gap_d;
`else
  typedef enum logic {IDLE, OWN} st_t;
`endif

  st_t           state_q, state_d;
  idx_t          ptr_q, ptr_d;
  idx_t          own_q, own_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          act;

  logic [N_REQ-1:0] gnt_d;
  logic [5:0]       n3_d, n2_d, n1_d, n0_d;

  logic [PW:0]      pick_p, pick_o;
  idx_t             nxt;
  logic [N_REQ-1:0] own_mask;
  logic             rel, pre;

  function automatic idx_t wrap_inc(input idx_t i);
    return (i == idx_t'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // first requester at or after base, with wrap; MSB = found
  function automatic logic [PW:0] pick(input idx_t base,
                                       input logic [N_REQ-1:0] r);
    logic [PW:0] res;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(base) + k) % N_REQ;
      if (r[j]) res = {1'b1, idx_t'(j)};
    end
    return res;
  endfunction

  function automatic logic [5:0] clamp(input logic [5:0] v);
    return (v > 6'd17) ? OFF : v;
  endfunction

  assign nxt      = wrap_inc(own_q);
  assign pick_p   = pick(ptr_q, req);
  assign pick_o   = pick(nxt, req);
  assign own_mask = N_REQ'(1) << own_q;
  assign rel      = !req[own_q];
  assign pre      = (hold_q == HOLD_TOP) && |(req & ~own_mask);

  // next state, owner selection and next display contents
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    hold_d  = hold_q;
    act     = 1'b0;
`ifdef DISP_ARB_GAP_EN
    gap_d   = gap_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_p[PW]) begin
          state_d = OWN;
          own_d   = pick_p[PW-1:0];
          hold_d  = '0;
          act     = 1'b1;
        end
      end
      OWN: begin
        if (rel || pre) begin
          ptr_d  = nxt;
          hold_d = '0;
`ifdef DISP_ARB_GAP_EN
          state_d = GAP;
          gap_d   = '0;
`else
          if (pick_o[PW]) begin
            own_d = pick_o[PW-1:0];
            act   = 1'b1;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          act = 1'b1;
          if (hold_q != HOLD_TOP) hold_d = hold_q + 1'b1;
        end
      end
`ifdef DISP_ARB_GAP_EN
      GAP: begin
        if (gap_q == GAP_TOP) begin
          if (pick_p[PW]) begin
            state_d = OWN;
            own_d   = pick_p[PW-1:0];
            hold_d  = '0;
            act     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    gnt_d = '0;
    n3_d  = OFF;
    n2_d  = OFF;
    n1_d  = OFF;
    n0_d  = OFF;
    if (act) begin
      gnt_d = N_REQ'(1) << own_d;
      n3_d  = clamp(digits_in[int'(own_d)*24+18 +: 6]);
      n2_d  = clamp(digits_in[int'(own_d)*24+12 +: 6]);
      n1_d  = clamp(digits_in[int'(own_d)*24+6  +: 6]);
      n0_d  = clamp(digits_in[int'(own_d)*24    +: 6]);
    end
  end

  // state and output registers; gnt and num always move together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      hold_q  <= '0;
`ifdef DISP_ARB_GAP_EN
      gap_q   <= '0;
`endif
      gnt     <= '0;
      num3    <= OFF;
      num2    <= OFF;
      num1    <= OFF;
      num0    <= OFF;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
`ifdef DISP_ARB_GAP_EN
      gap_q   <= gap_d;
`endif
      gnt     <= gnt_d;
      num3    <= n3_d;
      num2    <= n2_d;
      num1    <= n1_d;
      num0    <= n0_d;
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter.
// N_REQ=4, MAX_HOLD=8, GAP_CYCLES=3.
module tb_display_share_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int GC = 3;
`ifdef DISP_ARB_GAP_EN
  localparam int GAP = GC;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [95:0] digits_in;
  logic [3:0]  gnt;
  logic [5:0]  num3, num2, num1, num0;
  logic        busy;

  logic [5:0] dg [4][4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    digits_in = '0;
    for (int i = 0; i < 4; i++)
      digits_in[24*i +: 24] = {dg[i][3], dg[i][2], dg[i][1], dg[i][0]};
  end

  display_share_arbiter #(
    .N_REQ(N), .MAX_HOLD(MH), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .digits_in(digits_in),
    .gnt(gnt), .num3(num3), .num2(num2), .num1(num1),
    .num0(num0), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] cl(input logic [5:0] v);
    return (v > 6'd17) ? 6'd16 : v;
  endfunction

  task automatic chk_out(input string tag, input logic [3:0] g,
                         input logic [5:0] e3, input logic [5:0] e2,
                         input logic [5:0] e1, input logic [5:0] e0);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(|g));
    chk({tag, ".num3"}, 32'(num3), 32'(e3));
    chk({tag, ".num2"}, 32'(num2), 32'(e2));
    chk({tag, ".num1"}, 32'(num1), 32'(e1));
    chk({tag, ".num0"}, 32'(num0), 32'(e0));
  endtask

  task automatic off(input string tag);
    chk_out(tag, 4'b0000, 6'd16, 6'd16, 6'd16, 6'd16);
  endtask

  task automatic own(input string tag, input int i);
    chk_out(tag, 4'(1 << i), cl(dg[i][3]), cl(dg[i][2]),
            cl(dg[i][1]), cl(dg[i][0]));
  endtask

  // handoff edge, then any blank gap, then the new owner
  task automatic handoff(input string tag, input int i);
    for (int k = 0; k < GAP; k++) begin
      tick;
      off({tag, ".gap"});
    end
    tick;
    own(tag, i);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    dg[0][3] = 6'd10; dg[0][2] = 6'd11; dg[0][1] = 6'd12; dg[0][0] = 6'd13;
    dg[1][3] = 6'd5;  dg[1][2] = 6'd6;  dg[1][1] = 6'd7;  dg[1][0] = 6'd8;
    dg[2][3] = 6'd1;  dg[2][2] = 6'd2;  dg[2][1] = 6'd3;  dg[2][0] = 6'd4;
    dg[3][3] = 6'd17; dg[3][2] = 6'd63; dg[3][1] = 6'd15; dg[3][0] = 6'd0;

    // reset held two cycles with all requests high
    rst = 1'b1;
    req = 4'b1111;
    tick;
    off("rst1");
    tick;
    off("rst2");
    rst = 1'b0;
    tick;
    own("rst_rel", 0);

    // single requester, latency and clamp
    do_reset;
    req = 4'b0000;
    tick;
    req = 4'b0100;
    off("single_pre");
    tick;
    own("single", 2);
    dg[2][0] = 6'd17;
    tick;
    chk("dash_num0", 32'(num0), 32'd17);
    dg[2][0] = 6'd40;
    tick;
    chk("clamp_num0", 32'(num0), 32'd16);
    dg[2][0] = 6'd4;
    req = 4'b0000;
    for (int k = 0; k < GAP; k++) tick;
    tick;
    off("single_idle");

    // preemption and fairness
    do_reset;
    req = 4'b0011;
    tick;
    own("pre_g0", 0);
    for (int k = 0; k < MH - 1; k++) begin
      tick;
      own("pre_h0", 0);
    end
    handoff("pre_to1", 1);
    for (int k = 0; k < MH - 1; k++) begin
      tick;
      own("pre_h1", 1);
    end
    handoff("pre_to0", 0);

    // release by owner 2 with ptr=3 wraps to requester 0
    do_reset;
    req = 4'b0100;
    tick;
    own("rel_a", 2);
    req = 4'b0000;
    for (int k = 0; k < GAP; k++) tick;
    tick;
    off("rel_idle");
    req = 4'b0100;
    tick;
    own("rel_b", 2);
    req = 4'b0101;
    tick;
    own("rel_keep", 2);
    req = 4'b0001;
    handoff("rel_wrap", 0);
    req = 4'b0011;
    for (int k = 0; k < MH - 1; k++) tick;
    own("rel_restart", 0);
    handoff("rel_pre", 1);

    // sole owner at saturation, then a challenger
    do_reset;
    req = 4'b1000;
    tick;
    own("sole_g", 3);
    for (int k = 0; k < 49; k++) begin
      tick;
      own("sole_h", 3);
    end
    req = 4'b1010;
    handoff("sole_pre", 1);
    req = 4'b1000;
    handoff("sole_rel", 3);

    // reset mid-ownership restarts from ptr=0
    rst = 1'b1;
    tick;
    off("mid_rst");
    rst = 1'b0;
    req = 4'b1001;
    tick;
    own("mid_ptr0", 0);

`ifdef DISP_ARB_GAP_EN
    // reset during the blank gap
    req = 4'b1000;
    tick;
    off("gap_enter");
    rst = 1'b1;
    tick;
    off("gap_rst");
    rst = 1'b0;
    req = 4'b0010;
    tick;
    own("gap_after_rst", 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
